// File: rtl/univ_reg_if.sv
// Bus bundle for univ_reg: mode/transfer controls in, register contents and flags out.
interface univ_reg_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             co;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, sin, start,
    input  q, sout, co, zero, busy, done
  );

  modport slave (
    input  en, mode, d, sin, start,
    output q, sout, co, zero, busy, done
  );
endinterface

// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/count modes plus an
// LSB-first full-duplex serial transfer engine.
module univ_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  univ_reg_if.slave  bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  // co is a one-cycle flag: it is cleared unless the current operation sets it.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    co_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d     = bus.d;
          cnt_d   = '0;
          state_d = XFER;
        end else if (bus.en) begin
          case (bus.mode)
            3'b000: q_d = q_q;
            3'b001: q_d = bus.d;
            3'b010: begin
              q_d  = {q_q[WIDTH-2:0], bus.sin};
              co_d = q_q[WIDTH-1];
            end
            3'b011: begin
              q_d  = {bus.sin, q_q[WIDTH-1:1]};
              co_d = q_q[0];
            end
            3'b100: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            3'b101: q_d = {q_q[0], q_q[WIDTH-1:1]};
            3'b110: begin
              q_d  = q_q + 1'b1;
              co_d = &q_q;
            end
            default: begin
              q_d  = q_q - 1'b1;
              co_d = (q_q == '0);
            end
          endcase
        end
      end
      XFER: begin
        q_d = {bus.sin, q_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.q    = q_q;
  assign bus.co   = co_q;
  assign bus.sout = q_q[0];
  assign bus.zero = (q_q == '0);
  assign bus.busy = (state_q == XFER);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg: directed scenarios followed by random
// traffic, all checked against an arithmetic reference model.
module tb_univ_reg;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;

  logic clk = 1'b0;
  logic reset;

  univ_reg_if #(.WIDTH(W)) bus ();

  univ_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: m_t counts edges since a transfer began (0 = no transfer in progress).
  int m_q  = 0;
  int m_co = 0;
  int m_t  = 0;
  int m_rx = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int r, input int en, input int mode,
                            input int d, input int sin, input int start);
    int md;
    md = 1 << W;
    if (r != 0) begin
      m_q = RV; m_co = 0; m_t = 0;
    end else if (m_t == 0) begin
      if (start != 0) begin
        m_q = d; m_co = 0; m_t = 1; m_rx = 0;
      end else if (en != 0) begin
        case (mode)
          0: m_co = 0;
          1: begin m_q = d; m_co = 0; end
          2: begin m_co = m_q / (md / 2); m_q = (m_q * 2 + sin) % md; end
          3: begin m_co = m_q % 2; m_q = m_q / 2 + sin * (md / 2); end
          4: begin m_co = 0; m_q = (m_q * 2) % md + m_q / (md / 2); end
          5: begin m_co = 0; m_q = m_q / 2 + (m_q % 2) * (md / 2); end
          6: begin m_co = (m_q == md - 1) ? 1 : 0; m_q = (m_q + 1) % md; end
          default: begin m_co = (m_q == 0) ? 1 : 0; m_q = (m_q + md - 1) % md; end
        endcase
      end else begin
        m_co = 0;
      end
    end else if (m_t <= W) begin
      m_rx = m_rx + (sin << (m_t - 1));
      m_q  = m_q / 2 + sin * (md / 2);
      m_co = 0;
      m_t++;
    end else begin
      m_t = 0; m_co = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit en, input logic [2:0] mode,
                               input logic [7:0] d, input bit sin, input bit start);
    reset     = r;
    bus.en    = en;
    bus.mode  = mode;
    bus.d     = d;
    bus.sin   = sin;
    bus.start = start;
    model_step(int'(r), int'(en), int'(mode), int'(d), int'(sin), int'(start));
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "_q"},    32'(bus.q),    m_q);
    cmp({tag, "_co"},   32'(bus.co),   m_co);
    cmp({tag, "_zero"}, 32'(bus.zero), (m_q == 0) ? 1 : 0);
    cmp({tag, "_sout"}, 32'(bus.sout), m_q % 2);
    cmp({tag, "_busy"}, 32'(bus.busy), (m_t >= 1 && m_t <= W) ? 1 : 0);
    cmp({tag, "_done"}, 32'(bus.done), (m_t == W + 1) ? 1 : 0);
    if (m_t == W + 1) cmp({tag, "_rx"}, 32'(bus.q), m_rx);
  endtask

  initial begin
    logic [7:0] sin_seq;
    logic [7:0] sout_seq;
    bit         saw_done;

    applyStimulus(1, 0, 3'b000, 8'h00, 0, 0);
    applyStimulus(1, 0, 3'b000, 8'h00, 0, 0);
    checkOutput("reset");
    applyStimulus(0, 0, 3'b000, 8'h00, 0, 0);
    checkOutput("post_reset");
    cmp("reset_val", 32'(bus.q), 32'h5A);

    applyStimulus(0, 1, 3'b001, 8'hA5, 0, 0);
    checkOutput("load_a5");
    applyStimulus(0, 1, 3'b010, 8'h00, 0, 0);
    checkOutput("shl");
    cmp("shl_lit_q", 32'(bus.q), 32'h4A);
    cmp("shl_lit_co", 32'(bus.co), 32'h1);
    applyStimulus(0, 1, 3'b011, 8'h00, 1, 0);
    checkOutput("shr");
    cmp("shr_lit_q", 32'(bus.q), 32'hA5);

    applyStimulus(0, 1, 3'b001, 8'h81, 0, 0);
    applyStimulus(0, 1, 3'b100, 8'h00, 0, 0);
    checkOutput("rol");
    cmp("rol_lit_q", 32'(bus.q), 32'h03);
    applyStimulus(0, 1, 3'b101, 8'h00, 0, 0);
    checkOutput("ror");
    applyStimulus(0, 0, 3'b110, 8'h00, 0, 0);
    checkOutput("en_off");
    cmp("en_off_lit_q", 32'(bus.q), 32'h81);

    applyStimulus(0, 1, 3'b001, 8'hFF, 0, 0);
    applyStimulus(0, 1, 3'b110, 8'h00, 0, 0);
    checkOutput("up_wrap");
    cmp("up_wrap_lit_zero", 32'(bus.zero), 32'h1);
    applyStimulus(0, 1, 3'b111, 8'h00, 0, 0);
    checkOutput("down_wrap");
    applyStimulus(0, 1, 3'b111, 8'h00, 0, 0);
    checkOutput("down");
    cmp("down_lit_q", 32'(bus.q), 32'hFE);

    sin_seq  = 8'h4D;
    sout_seq = 8'hC3;
    applyStimulus(0, 0, 3'b000, 8'hC3, 0, 1);
    for (int k = 0; k < W; k++) begin
      checkOutput("xfer");
      cmp("xfer_sout_lit", 32'(bus.sout), 32'(sout_seq[k]));
      applyStimulus(0, 1, 3'b001, 8'h11, sin_seq[k], (k == 3) ? 1'b1 : 1'b0);
    end
    checkOutput("xfer_done");
    cmp("xfer_rx_lit", 32'(bus.q), 32'h4D);
    applyStimulus(0, 0, 3'b000, 8'h00, 0, 0);
    checkOutput("xfer_idle");

    applyStimulus(0, 0, 3'b000, 8'hF0, 0, 1);
    applyStimulus(0, 0, 3'b000, 8'h00, 1, 0);
    applyStimulus(0, 0, 3'b000, 8'h00, 1, 0);
    applyStimulus(1, 0, 3'b000, 8'h00, 1, 1);
    checkOutput("mid_reset");
    cmp("mid_reset_lit_q", 32'(bus.q), 32'h5A);
    saw_done = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      applyStimulus(0, 0, 3'b000, 8'h00, 0, 0);
      if (bus.done) saw_done = 1'b1;
    end
    cmp("mid_reset_no_done", 32'(saw_done), 32'h0);
    applyStimulus(0, 0, 3'b000, 8'($urandom), 0, 1);
    for (int k = 0; k <= W; k++) begin
      checkOutput("xfer2");
      applyStimulus(0, 0, 3'b000, 8'h00, 1'($urandom), 0);
    end
    checkOutput("xfer2_end");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 60) == 0, 1'($urandom), 3'($urandom),
                    8'($urandom), 1'($urandom), ($urandom % 10) == 0);
      checkOutput("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised universal register: the successor to the single-bit D flip-flop, generalised to a WIDTH-bit word with eight operating modes (hold, load, shift, rotate, up/down count) and an autonomous serial-transfer engine. It is the storage/shift primitive for datapath registers, counters and serial links in the project. It produces a registered carry-out flag and a combinational zero flag.

## Interface

Parameters:
- WIDTH, 8, word width; legal range WIDTH >= 2.
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  enables the mode operation while idle.
- mode  input  3  operation select (see Operation).
- d  input  WIDTH  parallel load data; also the transfer word for start.
- sin  input  1  serial input for shifts and transfers.
- start  input  1  begins a WIDTH-bit serial transfer when idle.
- q  output  WIDTH  register contents.
- sout  output  1  serial output, combinational: always q[0].
- co  output  1  registered carry/shift-out flag.
- zero  output  1  combinational: 1 when q == 0.
- busy  output  1  1 while a transfer is shifting.
- done  output  1  one-cycle pulse when a transfer completes.

## Operation

- Reset: q = RESET_VAL, co = 0, state IDLE, bit counter = 0, busy = 0, done = 0. Reset overrides all other inputs.
- FSM states: IDLE, XFER, DONE.
- IDLE, start = 1: q <= d, counter <= 0, go to XFER. start has priority over en/mode. co <= 0.
- IDLE, start = 0, en = 1, by mode:
  - 000 hold: q unchanged, co <= 0.
  - 001 load: q <= d, co <= 0.
  - 010 shift left: q <= {q[WIDTH-2:0], sin}, co <= old q[WIDTH-1].
  - 011 shift right: q <= {sin, q[WIDTH-1:1]}, co <= old q[0].
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}, co <= 0.
  - 101 rotate right: q <= {q[0], q[WIDTH-1:1]}, co <= 0.
  - 110 count up: q <= q + 1 modulo 2^WIDTH, co <= 1 only when old q is all-ones.
  - 111 count down: q <= q - 1 modulo 2^WIDTH, co <= 1 only when old q is 0.
- IDLE, start = 0, en = 0: q holds, co <= 0.
- XFER: each cycle shift right with sin into MSB, counter increments; on the cycle counter == WIDTH-1, go to DONE. en, mode, start ignored. co <= 0.
- DONE: q holds, done = 1, go to IDLE next cycle. en, mode, start ignored.
- Counter width: $clog2(WIDTH) bits, never exceeds WIDTH-1.

## Timing

- Mode operations: result visible on q one cycle after the enabling edge; co in the same cycle as q.
- Transfer: start sampled at edge 0 -> XFER for exactly WIDTH cycles (busy = 1) -> DONE for 1 cycle (done = 1) -> IDLE. A new start is accepted no earlier than the first IDLE cycle, i.e. WIDTH+1 cycles after the previous start.
- During XFER cycle k (k = 0..WIDTH-1), sout = d[k] (LSB first); sin sampled at the end of cycle k lands in q[k] after completion. Full-duplex: q holds the received word during DONE.
- busy and done are registered-state decodes, never both 1.
- Reset asserted mid-transfer: next cycle IDLE, q = RESET_VAL, no done pulse.
- zero and sout follow q combinationally with no extra latency.

## Test plan

- Reset with RESET_VAL = 8'h5A, then deassert with en = 0 -> q = 8'h5A, co = 0, busy = 0, done = 0, zero = 0, sout = 0.
- Load 8'hA5, shift left sin = 0 -> q = 8'h4A, co = 1; then shift right sin = 1 -> q = 8'hA5, co = 0.
- Load 8'h81, rotate left -> 8'h03; rotate right -> 8'h81; en = 0 with mode 110 -> q holds 8'h81.
- Load 8'hFF, count up -> q = 8'h00, co = 1, zero = 1; count down -> q = 8'hFF, co = 1; count down again -> 8'hFE, co = 0.
- start with d = 8'hC3, sin = 1,0,1,1,0,0,1,0 over the XFER cycles -> sout = 1,1,0,0,0,0,1,1; busy high 8 cycles; done high 1 cycle; q = 8'h4D; a start pulse during busy is ignored.
- start with d = 8'hF0, assert reset in the 3rd XFER cycle -> next cycle q = RESET_VAL, busy = 0, done never asserts; a following start runs a full 8-cycle transfer.
